// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART ACK link.
// Optional build macro: UART_PARITY_EN adds an even-parity bit to every frame.
package uart_pkg;

  // Default acknowledgement byte returned by the far end.
  localparam logic [7:0] UART_ACK_DEFAULT = 8'b11001100;

  // Transmit/ACK link FSM states; PARITY exists only in parity builds.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_ACK
`ifdef UART_PARITY_EN
    ,
    PARITY
`endif
  } link_state_t;

  // Receiver FSM states; RX_PARITY is only entered in parity builds.
  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  // Clock cycles per UART bit (integer division, truncating).
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// ACK byte receiver: 2-flop synchroniser, start-bit validation at mid-bit,
// mid-bit data sampling (LSB first) and stop-bit check.
// Optional build macro: UART_PARITY_EN expects an even-parity bit before stop;
// a parity mismatch is reported through frame_err_o.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int UART_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 8
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  rx_i,
  output logic [UART_WIDTH-1:0] byte_o,
  output logic                  byte_valid_o,
  output logic                  frame_err_o,
  output logic                  busy_o,
  output rx_state_t             state_o
);

  localparam int CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW   = (UART_WIDTH > 1) ? $clog2(UART_WIDTH) : 1;
  localparam int HALF = (CLKS_PER_BIT / 2 > 0) ? CLKS_PER_BIT / 2 - 1 : 0;

  logic [1:0]            sync_q;
  logic                  prev_q;
  rx_state_t             state_q;
  logic [CW-1:0]         cnt_q;
  logic [BW-1:0]         bit_q;
  logic [UART_WIDTH-1:0] sh_q;
  logic                  byte_valid_q;
  logic                  frame_err_q;
`ifdef UART_PARITY_EN
  logic                  par_q;
`endif

  logic rx_s;
  logic bit_end;
  assign rx_s    = sync_q[1];
  assign bit_end = (cnt_q == CW'(CLKS_PER_BIT - 1));

  // Synchronise rx, detect the falling edge, then walk start/data/stop at mid-bit.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      sync_q       <= 2'b11;
      prev_q       <= 1'b1;
      state_q      <= RX_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      sh_q         <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef UART_PARITY_EN
      par_q        <= 1'b0;
`endif
    end else begin
      sync_q       <= {sync_q[0], rx_i};
      prev_q       <= rx_s;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      case (state_q)
        RX_IDLE: begin
          if (prev_q && !rx_s) begin
            state_q <= RX_START;
            cnt_q   <= '0;
          end
        end
        RX_START: begin
          if (cnt_q == CW'(HALF)) begin
            cnt_q <= '0;
            if (!rx_s) begin
              state_q <= RX_DATA;
              bit_q   <= '0;
`ifdef UART_PARITY_EN
              par_q   <= 1'b0;
`endif
            end else begin
              // Glitch: line went back high before mid start bit.
              state_q <= RX_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RX_DATA: begin
          if (bit_end) begin
            cnt_q <= '0;
            sh_q  <= {rx_s, sh_q[UART_WIDTH-1:1]};
`ifdef UART_PARITY_EN
            par_q <= par_q ^ rx_s;
`endif
            if (bit_q == BW'(UART_WIDTH - 1)) begin
`ifdef UART_PARITY_EN
              state_q <= RX_PARITY;
`else
              state_q <= RX_STOP;
`endif
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
`ifdef UART_PARITY_EN
        RX_PARITY: begin
          if (bit_end) begin
            cnt_q   <= '0;
            // Even parity: data xor parity bit must be zero.
            par_q   <= par_q ^ rx_s;
            state_q <= RX_STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
`endif
        RX_STOP: begin
          if (bit_end) begin
            cnt_q        <= '0;
            byte_valid_q <= 1'b1;
`ifdef UART_PARITY_EN
            frame_err_q  <= !rx_s || par_q;
`else
            frame_err_q  <= !rx_s;
`endif
            state_q      <= RX_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

  assign byte_o       = sh_q;
  assign byte_valid_o = byte_valid_q;
  assign frame_err_o  = frame_err_q;
  assign busy_o       = (state_q == RX_DATA) || (state_q == RX_PARITY) || (state_q == RX_STOP);
  assign state_o      = state_q;

endmodule

// File: rtl/uart_ack_link.sv
// UART transmit link with ACK/retry: sends a DATA_WIDTH word as consecutive
// UART_WIDTH-bit frames (least-significant slice first), then waits for the
// ACK byte on rx; a wrong byte, framing error or timeout retransmits the word
// up to MAX_RETRIES times.
// Optional build macro: UART_PARITY_EN inserts an even-parity bit before STOP.
//
// Handshake: a word is accepted on a cycle where din_valid && din_ready;
// din_ready is high only in IDLE and din_valid at any other time is ignored.
module uart_ack_link
  import uart_pkg::*;
#(
  parameter int                    DATA_WIDTH     = 16,
  parameter int                    UART_WIDTH     = 8,
  parameter int                    CLK_FREQ       = 50_000_000,
  parameter int                    UART_BAUD_RATE = 19200,
  parameter logic [UART_WIDTH-1:0] UART_ACK       = UART_WIDTH'(UART_ACK_DEFAULT),
  parameter int                    ACK_TIMEOUT    = 100_000,
  parameter int                    MAX_RETRIES    = 3
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic                  tx,
  input  logic                  rx,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [((MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1)-1:0] retry_count,
  output link_state_t           state_dbg
);

  localparam int CPB = clks_per_bit(CLK_FREQ, UART_BAUD_RATE);
  localparam int NF  = DATA_WIDTH / UART_WIDTH;
  localparam int RW  = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int BW  = (UART_WIDTH > 1) ? $clog2(UART_WIDTH) : 1;
  localparam int FW  = (NF > 1) ? $clog2(NF) : 1;
  localparam int TW  = $clog2(ACK_TIMEOUT + 1);

  link_state_t           state_q;
  logic                  tx_q;
  logic                  done_q;
  logic                  error_q;
  logic [RW-1:0]         retry_q;
  logic [DATA_WIDTH-1:0] word_q;
  logic [DATA_WIDTH-1:0] sh_q;
  logic [CW-1:0]         cnt_q;
  logic [BW-1:0]         bit_q;
  logic [FW-1:0]         frame_q;
  logic [TW-1:0]         timer_q;
`ifdef UART_PARITY_EN
  logic                  par_q;
`endif

  logic [UART_WIDTH-1:0] rx_byte;
  logic                  rx_valid;
  logic                  rx_err;
  logic                  rx_busy;
  rx_state_t             rx_state;

  logic bit_end;
  logic ack_ok_d;
  logic fail_d;

  uart_rx_byte #(
    .UART_WIDTH  (UART_WIDTH),
    .CLKS_PER_BIT(CPB)
  ) u_rx (
    .clk         (clk),
    .rstN        (rstN),
    .rx_i        (rx),
    .byte_o      (rx_byte),
    .byte_valid_o(rx_valid),
    .frame_err_o (rx_err),
    .busy_o      (rx_busy),
    .state_o     (rx_state)
  );

  assign bit_end = (cnt_q == CW'(CPB - 1));

  // WAIT_ACK outcome; a completed byte takes priority over the timeout.
  always_comb begin
    ack_ok_d = 1'b0;
    fail_d   = 1'b0;
    if (state_q == WAIT_ACK) begin
      if (rx_valid) begin
        if (!rx_err && (rx_byte == UART_ACK)) ack_ok_d = 1'b1;
        else                                  fail_d   = 1'b1;
      end else if (!rx_busy && (timer_q == TW'(ACK_TIMEOUT - 1))) begin
        fail_d = 1'b1;
      end
    end
  end

  // Link FSM: serialise frames from a shifting copy of the word, then await ACK.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= IDLE;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      retry_q <= '0;
      word_q  <= '0;
      sh_q    <= '0;
      cnt_q   <= '0;
      bit_q   <= '0;
      frame_q <= '0;
      timer_q <= '0;
`ifdef UART_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (din_valid && din_ready) begin
            word_q  <= din;
            sh_q    <= din;
            retry_q <= '0;
            frame_q <= '0;
            cnt_q   <= '0;
            tx_q    <= 1'b0;
            state_q <= START;
          end
        end
        START: begin
          if (bit_end) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            tx_q    <= sh_q[0];
            sh_q    <= sh_q >> 1;
`ifdef UART_PARITY_EN
            par_q   <= sh_q[0];
`endif
            state_q <= DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (bit_q == BW'(UART_WIDTH - 1)) begin
`ifdef UART_PARITY_EN
              tx_q    <= par_q;
              state_q <= PARITY;
`else
              tx_q    <= 1'b1;
              state_q <= STOP;
`endif
            end else begin
              bit_q <= bit_q + 1'b1;
              tx_q  <= sh_q[0];
              sh_q  <= sh_q >> 1;
`ifdef UART_PARITY_EN
              par_q <= par_q ^ sh_q[0];
`endif
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
`ifdef UART_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            cnt_q   <= '0;
            tx_q    <= 1'b1;
            state_q <= STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (frame_q == FW'(NF - 1)) begin
              timer_q <= '0;
              state_q <= WAIT_ACK;
            end else begin
              // Next frame starts immediately, no idle gap.
              frame_q <= frame_q + 1'b1;
              tx_q    <= 1'b0;
              state_q <= START;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        WAIT_ACK: begin
          if (ack_ok_d) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else if (fail_d) begin
            if (int'(retry_q) < MAX_RETRIES) begin
              retry_q <= retry_q + 1'b1;
              sh_q    <= word_q;
              frame_q <= '0;
              cnt_q   <= '0;
              tx_q    <= 1'b0;
              state_q <= START;
            end else begin
              error_q <= 1'b1;
              state_q <= IDLE;
            end
          end else if (!rx_busy) begin
            // Timer freezes while an ACK byte is being received.
            timer_q <= timer_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign din_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign tx          = tx_q;
  assign done        = done_q;
  assign error       = error_q;
  assign retry_count = retry_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_uart_ack_link.sv
// Bench for uart_ack_link: a tx frame monitor decodes frames and checks them
// against an expected-byte queue filled by the scenario tasks.
`timescale 1ns/1ps
module tb_uart_ack_link;
  import uart_pkg::*;

  localparam int CPB = 8;
`ifdef UART_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  // ---------------- clock / reset ----------------
  logic        clk       = 1'b0;
  logic        rstN      = 1'b0;
  logic [15:0] din       = '0;
  logic        din_valid = 1'b0;
  logic        rx        = 1'b1;
  logic        din_ready, tx, busy, done, error;
  logic [1:0]  retry_count;
  link_state_t state_dbg;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  uart_ack_link #(
    .DATA_WIDTH    (16),
    .UART_WIDTH    (8),
    .CLK_FREQ      (153600),
    .UART_BAUD_RATE(19200),
    .UART_ACK      (8'hCC),
    .ACK_TIMEOUT   (200),
    .MAX_RETRIES   (2)
  ) dut (
    .clk        (clk),
    .rstN       (rstN),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .tx         (tx),
    .rx         (rx),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .retry_count(retry_count),
    .state_dbg  (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int         n_vec = 0;
  int         n_mis = 0;
  logic [7:0] exp_q[$];

  int         done_cnt = 0;
  int         err_cnt  = 0;
  logic [1:0] done_retry = '0;
  logic [1:0] err_retry  = '0;

  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      done_retry = retry_count;
    end
    if (error) begin
      err_cnt++;
      err_retry = retry_count;
    end
  end

  // ---------------- tx monitor ----------------
  logic tx_prev    = 1'b1;
  int   frame_idx  = 0;
  int   last_start = 0;

  task automatic mon_wait(input int n, inout bit ok);
    for (int i = 0; i < n; i++) begin
      if (!ok) return;
      @(negedge clk);
      if (!rstN) ok = 1'b0;
    end
  endtask

  task automatic mon_frame();
    bit         ok = 1'b1;
    logic [7:0] got;
    logic [7:0] exp;
    logic       s0, sbit;
    logic       pbit;
    int         st;
    st   = cyc;
    pbit = 1'b0;
    got  = '0;
    mon_wait(3, ok);
    s0 = tx;
    for (int i = 0; i < 8; i++) begin
      mon_wait(CPB, ok);
      got[i] = tx;
    end
`ifdef UART_PARITY_EN
    mon_wait(CPB, ok);
    pbit = tx;
`endif
    mon_wait(CPB, ok);
    sbit = tx;
    if (!ok) begin
      frame_idx = 0;
      return;
    end
    n_vec++;
    if (s0 !== 1'b0) begin
      n_mis++;
      $display("FAIL start_bit: got %b want 0", s0);
    end
    n_vec++;
    if (exp_q.size() == 0) begin
      n_mis++;
      $display("FAIL unexpected_frame: got %h want no frame", got);
    end else begin
      exp = exp_q.pop_front();
      if (got !== exp) begin
        n_mis++;
        $display("FAIL frame_data: got %h want %h", got, exp);
      end
`ifdef UART_PARITY_EN
      n_vec++;
      if (pbit !== ^exp) begin
        n_mis++;
        $display("FAIL parity_bit: got %b want %b (byte %h)", pbit, ^exp, exp);
      end
`endif
    end
    n_vec++;
    if (sbit !== 1'b1) begin
      n_mis++;
      $display("FAIL stop_bit: got %b want 1", sbit);
    end
    if (frame_idx == 1) begin
      n_vec++;
      if (st - last_start != FRAME_BITS * CPB) begin
        n_mis++;
        $display("FAIL frame_spacing: got %0d cycles want %0d", st - last_start, FRAME_BITS * CPB);
      end
    end
    last_start = st;
    frame_idx  = (frame_idx + 1) % 2;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rstN && tx_prev && !tx) mon_frame();
      tx_prev = tx;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_word(input logic [15:0] d);
    @(negedge clk);
    n_vec++;
    if (din_ready !== 1'b1) begin
      n_mis++;
      $display("FAIL din_ready_before_send: got %b want 1", din_ready);
    end
    din       = d;
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    n_vec++;
    if (busy !== 1'b1 || din_ready !== 1'b0) begin
      n_mis++;
      $display("FAIL busy_after_accept: got busy=%b ready=%b want busy=1 ready=0", busy, din_ready);
    end
  endtask

  task automatic send_ack(input logic [7:0] b, input bit bad_par);
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef UART_PARITY_EN
    rx = (^b) ^ bad_par;
    repeat (CPB) @(negedge clk);
`else
    if (bad_par) $display("note: parity request ignored in this build");
`endif
    rx = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic wait_exp_empty(input int bound, input string name);
    int i = 0;
    while (exp_q.size() != 0 && i < bound) begin
      @(negedge clk);
      i++;
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_mis++;
      $display("FAIL %s: %0d frames outstanding, want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic clear_counts();
    @(negedge clk);
    done_cnt = 0;
    err_cnt  = 0;
  endtask

  task automatic check_done(input string name, input logic [1:0] want_retry);
    repeat (10) @(negedge clk);
    n_vec++;
    if (done_cnt != 1 || err_cnt != 0) begin
      n_mis++;
      $display("FAIL %s_pulses: got done=%0d error=%0d want done=1 error=0", name, done_cnt, err_cnt);
    end
    n_vec++;
    if (done_retry !== want_retry) begin
      n_mis++;
      $display("FAIL %s_retry: got %0d want %0d", name, done_retry, want_retry);
    end
    n_vec++;
    if (din_ready !== 1'b1 || busy !== 1'b0) begin
      n_mis++;
      $display("FAIL %s_idle: got ready=%b busy=%b want ready=1 busy=0", name, din_ready, busy);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rstN = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if (tx !== 1'b1 || din_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 ||
        error !== 1'b0 || retry_count !== 2'd0 || state_dbg !== IDLE) begin
      n_mis++;
      $display("FAIL reset_state: got tx=%b rdy=%b busy=%b done=%b err=%b retry=%0d want 1 1 0 0 0 0",
               tx, din_ready, busy, done, error, retry_count);
    end
    rstN = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    clear_counts();
    exp_q.push_back(8'hC3);
    exp_q.push_back(8'hA5);
    start_word(16'hA5C3);
    wait_exp_empty(400, "basic_frames");
    send_ack(8'hCC, 1'b0);
    check_done("basic", 2'd0);
  endtask

  task automatic test_nack_retry();
    clear_counts();
    exp_q.push_back(8'hC3);
    exp_q.push_back(8'hA5);
    start_word(16'hA5C3);
    wait_exp_empty(400, "nack_first_frames");
    exp_q.push_back(8'hC3);
    exp_q.push_back(8'hA5);
    send_ack(8'h33, 1'b0);
    wait_exp_empty(400, "nack_retx_frames");
    n_vec++;
    if (retry_count !== 2'd1 || done_cnt != 0) begin
      n_mis++;
      $display("FAIL nack_retry_count: got retry=%0d done=%0d want retry=1 done=0", retry_count, done_cnt);
    end
    send_ack(8'hCC, 1'b0);
    check_done("nack", 2'd1);
  endtask

  task automatic test_timeout();
    int i = 0;
    clear_counts();
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(8'hC3);
      exp_q.push_back(8'hA5);
    end
    start_word(16'hA5C3);
    while (err_cnt == 0 && i < 3000) begin
      @(negedge clk);
      i++;
    end
    n_vec++;
    if (err_cnt == 0) begin
      n_mis++;
      $display("FAIL timeout_error_seen: got no error pulse within 3000 cycles want 1");
    end
    wait_exp_empty(0, "timeout_frames");
    repeat (5) @(negedge clk);
    n_vec++;
    if (err_cnt != 1 || done_cnt != 0 || err_retry !== 2'd2) begin
      n_mis++;
      $display("FAIL timeout_pulses: got err=%0d done=%0d retry=%0d want 1 0 2", err_cnt, done_cnt, err_retry);
    end
    n_vec++;
    if (retry_count !== 2'd2 || din_ready !== 1'b1) begin
      n_mis++;
      $display("FAIL timeout_hold: got retry=%0d ready=%b want 2 1", retry_count, din_ready);
    end
  endtask

  task automatic test_reset_mid_frame();
    clear_counts();
    exp_q.push_back(8'hC3);
    start_word(16'hA5C3);
    // Lands mid data bit 3 of frame 1.
    repeat (115) @(negedge clk);
    rstN = 1'b0;
    #1;
    n_vec++;
    if (tx !== 1'b1 || busy !== 1'b0 || din_ready !== 1'b1 || retry_count !== 2'd0) begin
      n_mis++;
      $display("FAIL reset_mid_frame: got tx=%b busy=%b rdy=%b retry=%0d want 1 0 1 0",
               tx, busy, din_ready, retry_count);
    end
    wait_exp_empty(0, "reset_frame0");
    repeat (3) @(negedge clk);
    rstN = 1'b1;
    clear_counts();
    exp_q.push_back(8'h34);
    exp_q.push_back(8'h12);
    start_word(16'h1234);
    wait_exp_empty(400, "after_reset_frames");
    send_ack(8'hCC, 1'b0);
    check_done("after_reset", 2'd0);
  endtask

  task automatic test_busy_ignore();
    clear_counts();
    exp_q.push_back(8'hC3);
    exp_q.push_back(8'hA5);
    start_word(16'hA5C3);
    repeat (30) @(negedge clk);
    din       = 16'hFFFF;
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    wait_exp_empty(400, "busy_frames");
    send_ack(8'hCC, 1'b0);
    check_done("busy_ignore", 2'd0);
    // Any stray frame from the ignored request is flagged by the monitor.
    repeat (200) @(negedge clk);
    n_vec++;
    if (busy !== 1'b0) begin
      n_mis++;
      $display("FAIL busy_ignore_idle: got busy=%b want 0", busy);
    end
  endtask

`ifdef UART_PARITY_EN
  task automatic test_parity();
    clear_counts();
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h00);
    start_word(16'h0001);
    wait_exp_empty(400, "parity_frames");
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h00);
    send_ack(8'hCC, 1'b1);
    wait_exp_empty(400, "parity_retx_frames");
    n_vec++;
    if (retry_count !== 2'd1 || done_cnt != 0) begin
      n_mis++;
      $display("FAIL parity_nack: got retry=%0d done=%0d want 1 0", retry_count, done_cnt);
    end
    send_ack(8'hCC, 1'b0);
    check_done("parity", 2'd1);
  endtask
`endif

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_basic();
    test_nack_retry();
    test_timeout();
    test_reset_mid_frame();
    test_busy_ignore();
`ifdef UART_PARITY_EN
    test_parity();
`endif
    repeat (20) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
